// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle HI/LO unit for MULT, MULTU, DIV and DIVU.
// The unit runs one shared 32-bit add/sub step per cycle for 32 cycles:
// shift-add for multiply and restoring division for divide.
// Optional feature macro: MULDIV_DIV_EN. When it is defined the division
// path is built. When it is undefined, DIV/DIVU finish in one cycle with
// dz set and HI/LO left unchanged.

// AddSub32_2_1: 32-bit carry-lookahead adder/subtractor.
// It computes a + (b ^ {32{mode}}) + cin, using 4-bit lookahead groups.
module AddSub32_2_1 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mode,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] bx_s;
  logic [31:0] g_s;
  logic [31:0] p_s;
  logic [32:0] c_s;

  // Generate/propagate terms and the group carries inside each 4-bit block.
  always_comb begin
    bx_s = b ^ {32{mode}};
    g_s  = a & bx_s;
    p_s  = a ^ bx_s;
    c_s  = 33'd0;
    c_s[0] = cin;
    for (int k = 0; k < 8; k++) begin
      c_s[4*k+1] = g_s[4*k] | (p_s[4*k] & c_s[4*k]);
      c_s[4*k+2] = g_s[4*k+1] | (p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+1] & p_s[4*k] & c_s[4*k]);
      c_s[4*k+3] = g_s[4*k+2] | (p_s[4*k+2] & g_s[4*k+1])
                 | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & c_s[4*k]);
      c_s[4*k+4] = g_s[4*k+3] | (p_s[4*k+3] & g_s[4*k+2])
                 | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
                 | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & c_s[4*k]);
    end
    sum  = p_s ^ c_s[31:0];
    cout = c_s[32];
  end

endmodule

module muldiv_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        dz,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_CALC = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  state_t      state_r;
  logic [4:0]  cnt_r;
  logic        sgn_r;      // operation is signed (MULT / DIV)
  logic [31:0] a_r;        // operand A as latched at start
  logic [31:0] b_r;        // operand B as latched at start
  logic [63:0] p_r;        // multiply: product; divide: {R, Q}
  logic [31:0] m_r;        // multiplicand magnitude or divisor magnitude
  logic        neg_r;      // result must be negated (signs differ)
`ifdef MULDIV_DIV_EN
  logic        div_r;      // operation is a divide
  logic        sa_r;       // dividend was negative (remainder sign)
`endif

  logic [31:0] abs_a_s;
  logic [31:0] abs_b_s;
  logic [31:0] add_a_s;
  logic        add_mode_s;
  logic        add_cin_s;
  logic [31:0] add_sum_s;
  logic        add_cout_s;
  logic [63:0] mul_next_s;
  logic [63:0] calc_next_s;
  logic [63:0] mul_res_s;
  logic [31:0] fix_hi_s;
  logic [31:0] fix_lo_s;
`ifdef MULDIV_DIV_EN
  logic [31:0] rsh_s;
  logic [31:0] qsh_s;
  logic [63:0] div_next_s;
`endif

  // Operand magnitudes for signed ops; unsigned ops pass through.
  always_comb begin
    if (sgn_r && a_r[31]) begin
      abs_a_s = 32'd0 - a_r;
    end else begin
      abs_a_s = a_r;
    end
    if (sgn_r && b_r[31]) begin
      abs_b_s = 32'd0 - b_r;
    end else begin
      abs_b_s = b_r;
    end
  end

  // Select the shared adder operands: add for multiply, subtract for divide.
  always_comb begin
`ifdef MULDIV_DIV_EN
    rsh_s = {p_r[62:32], p_r[31]};
    qsh_s = {p_r[30:0], 1'b0};
    if (div_r) begin
      add_a_s    = rsh_s;
      add_mode_s = 1'b1;
      add_cin_s  = 1'b1;
    end else begin
      add_a_s    = p_r[63:32];
      add_mode_s = 1'b0;
      add_cin_s  = 1'b0;
    end
`else
    add_a_s    = p_r[63:32];
    add_mode_s = 1'b0;
    add_cin_s  = 1'b0;
`endif
  end

  AddSub32_2_1 u_addsub (
    .a    (add_a_s),
    .b    (m_r),
    .mode (add_mode_s),
    .cin  (add_cin_s),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // Next iteration value: shift-add step, or restoring-division step.
  always_comb begin
    if (p_r[0]) begin
      mul_next_s = {add_cout_s, add_sum_s, p_r[31:1]};
    end else begin
      mul_next_s = {1'b0, p_r[63:32], p_r[31:1]};
    end
`ifdef MULDIV_DIV_EN
    // A set msb means R' overflowed 32 bits, so it is certainly >= D.
    if (p_r[63] || add_cout_s) begin
      div_next_s = {add_sum_s, qsh_s[31:1], 1'b1};
    end else begin
      div_next_s = {rsh_s, qsh_s};
    end
    if (div_r) begin
      calc_next_s = div_next_s;
    end else begin
      calc_next_s = mul_next_s;
    end
`else
    calc_next_s = mul_next_s;
`endif
  end

  // Final sign fix-up of the iterated result into HI/LO values.
  always_comb begin
    if (neg_r) begin
      mul_res_s = 64'd0 - p_r;
    end else begin
      mul_res_s = p_r;
    end
    fix_hi_s = mul_res_s[63:32];
    fix_lo_s = mul_res_s[31:0];
`ifdef MULDIV_DIV_EN
    if (div_r) begin
      if (dz) begin
        // Zero divisor: the sign fix-up is skipped on purpose.
        fix_hi_s = a_r;
        fix_lo_s = 32'hFFFF_FFFF;
      end else begin
        if (neg_r) begin
          fix_lo_s = 32'd0 - p_r[31:0];
        end else begin
          fix_lo_s = p_r[31:0];
        end
        if (sa_r) begin
          fix_hi_s = 32'd0 - p_r[63:32];
        end else begin
          fix_hi_s = p_r[63:32];
        end
      end
    end else begin
      fix_hi_s = mul_res_s[63:32];
      fix_lo_s = mul_res_s[31:0];
    end
`endif
  end

  // Sequencer FSM with registered status outputs and HI/LO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 5'd0;
      sgn_r   <= 1'b0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      p_r     <= 64'd0;
      m_r     <= 32'd0;
      neg_r   <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_r   <= 1'b0;
      sa_r    <= 1'b0;
`endif
      busy    <= 1'b0;
      done    <= 1'b0;
      dz      <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
`ifdef MULDIV_DIV_EN
            sgn_r   <= ~op[0];
            div_r   <= op[1];
            a_r     <= inA;
            b_r     <= inB;
            busy    <= 1'b1;
            state_r <= ST_PREP;
`else
            if (op[1]) begin
              // Divide is not built: report completion with dz at once.
              done <= 1'b1;
              dz   <= 1'b1;
            end else begin
              sgn_r   <= ~op[0];
              a_r     <= inA;
              b_r     <= inB;
              busy    <= 1'b1;
              state_r <= ST_PREP;
            end
`endif
          end else begin
            if (hi_we) begin
              hi <= wdata;
            end
            if (lo_we) begin
              lo <= wdata;
            end
          end
        end
        ST_PREP: begin
          p_r     <= {32'd0, abs_a_s};
          m_r     <= abs_b_s;
          neg_r   <= sgn_r & (a_r[31] ^ b_r[31]);
          cnt_r   <= 5'd0;
          state_r <= ST_CALC;
`ifdef MULDIV_DIV_EN
          sa_r    <= sgn_r & a_r[31];
          dz      <= div_r & (b_r == 32'd0);
`else
          dz      <= 1'b0;
`endif
        end
        ST_CALC: begin
          p_r   <= calc_next_s;
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            state_r <= ST_FIX;
          end
        end
        ST_FIX: begin
          hi      <= fix_hi_s;
          lo      <= fix_lo_s;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer. Expected results are hand-computed.
// Divide expectations follow the MULDIV_DIV_EN build option.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] inA;
  logic [31:0] inB;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        dz;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .inA   (inA),
    .inB   (inB),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; returns just after the negedge of cycle N+1.
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    inA   = a;
    inB   = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles from now, then checks the done-cycle outputs.
  task automatic wait_done(input string tag, input int exp_busy,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input logic exp_dz);
    int cnt;
    bit seen;
    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) begin
        seen = 1'b1;
        break;
      end
      cnt++;
      @(negedge clk);
    end
    check_eq({tag, " finished"}, 64'(seen), 64'd1);
    check_eq({tag, " busy_cycles"}, 64'(cnt), 64'(exp_busy));
    check_eq({tag, " done"}, 64'(done), 64'd1);
    check_eq({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check_eq({tag, " lo"}, 64'(lo), 64'(exp_lo));
    check_eq({tag, " dz"}, 64'(dz), 64'(exp_dz));
  endtask

  initial begin
    int activity;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    inA   = 32'd0;
    inB   = 32'd0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("reset busy", 64'(busy), 64'd0);
    check_eq("reset done", 64'(done), 64'd0);
    check_eq("reset dz", 64'(dz), 64'd0);
    check_eq("reset hi", 64'(hi), 64'd0);
    check_eq("reset lo", 64'(lo), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // MULTU max x max, then a back-to-back MULT started in the done cycle
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", 34, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    check_eq("b2b done_pulse_ends", 64'(done), 64'd0);
    wait_done("mult_m3x7", 34, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    @(negedge clk);
    check_eq("done one_cycle", 64'(done), 64'd0);

    start_op(2'b00, 32'h8000_0000, 32'h8000_0000);
    wait_done("mult_min_sq", 34, 32'h4000_0000, 32'h0000_0000, 1'b0);

`ifdef MULDIV_DIV_EN
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_m7_2", 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    start_op(2'b11, 32'd100, 32'd7);
    wait_done("divu_100_7", 34, 32'd2, 32'd14, 1'b0);
    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_min_m1", 34, 32'd0, 32'h8000_0000, 1'b0);
    start_op(2'b11, 32'd100, 32'd0);
    wait_done("divu_by0", 34, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
`else
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_off", 0, 32'h4000_0000, 32'h0000_0000, 1'b1);
    start_op(2'b11, 32'd100, 32'd0);
    wait_done("divu_off_by0", 0, 32'h4000_0000, 32'h0000_0000, 1'b1);
`endif

    // Multiply clears dz
    start_op(2'b01, 32'd3, 32'd5);
    wait_done("multu_3x5", 34, 32'd0, 32'd15, 1'b0);
    @(negedge clk);

    // MTHI / MTLO in IDLE
    hi_we = 1'b1;
    wdata = 32'h0000_1234;
    @(negedge clk);
    hi_we = 1'b0;
    check_eq("mthi hi", 64'(hi), 64'h1234);
    check_eq("mthi lo_kept", 64'(lo), 64'd15);
    lo_we = 1'b1;
    wdata = 32'h0000_ABCD;
    @(negedge clk);
    lo_we = 1'b0;
    check_eq("mtlo lo", 64'(lo), 64'hABCD);

    // MTLO in the same cycle as an accepted start is dropped
    lo_we = 1'b1;
    wdata = 32'h0000_5555;
    start_op(2'b01, 32'd6, 32'd7);
    lo_we = 1'b0;
    check_eq("mtlo_with_start lo", 64'(lo), 64'hABCD);
    check_eq("mtlo_with_start busy", 64'(busy), 64'd1);
    wait_done("multu_6x7", 34, 32'd0, 32'd42, 1'b0);
    @(negedge clk);

    // start and MTHI while busy are ignored
    start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    start = 1'b1;
    op    = 2'b01;
    inA   = 32'd1;
    inB   = 32'd1;
    hi_we = 1'b1;
    wdata = 32'h0000_1234;
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    check_eq("mthi_busy hi", 64'(hi), 64'd0);
    wait_done("mult_injected", 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    @(negedge clk);

    // Reset in CALC cycle 10 aborts the operation
`ifdef MULDIV_DIV_EN
    start_op(2'b11, 32'd100, 32'd7);
`else
    start_op(2'b01, 32'd100, 32'd7);
`endif
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("abort busy", 64'(busy), 64'd0);
    check_eq("abort done", 64'(done), 64'd0);
    check_eq("abort hi", 64'(hi), 64'd0);
    check_eq("abort lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    activity = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) begin
        activity++;
      end
    end
    check_eq("abort no_done", 64'(activity), 64'd0);
    start_op(2'b01, 32'd3, 32'd5);
    wait_done("after_abort", 34, 32'd0, 32'd15, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
